// File: rtl/jedro_1_writeback_pkg.sv
// jedro_1_writeback_pkg: shared types and constants for the jedro_1 writeback stage.
//   wb_entry_t    - one queued register-file write (data + destination address), default widths
//   wb_sel_e      - which source owns the register-file write port in a given cycle
//   WB_FIFO_DEPTH - default depth of the ALU result FIFO
package jedro_1_writeback_pkg;

    localparam int unsigned WB_DATA_WIDTH     = 32;
    localparam int unsigned WB_REG_ADDR_WIDTH = 5;
    localparam int unsigned WB_FIFO_DEPTH     = 4;

    typedef struct packed {
        logic [WB_DATA_WIDTH-1:0]     data;
        logic [WB_REG_ADDR_WIDTH-1:0] addr;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SelNone,
        SelFifo,
        SelLsu,
        SelAlu
    } wb_sel_e;

endpackage

// File: rtl/jedro_1_writeback_fifo.sv
// jedro_1_writeback_fifo: synchronous in-order FIFO for deferred ALU writeback entries.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (flushes all entries)
//   push_i/push_data_i  enqueue one entry at the tail
//   pop_i             dequeue the head entry
//   head_o            head entry (valid when !empty_o)
//   full_o, empty_o, count_o  occupancy
//   entries_o/valid_o per-entry read-out in age order: index 0 is the head (oldest)
module jedro_1_writeback_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [CNT_W-1:0]            count_o,
    output logic [DEPTH-1:0][WIDTH-1:0] entries_o,
    output logic [DEPTH-1:0]            valid_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
            valid_o[i]   = CNT_W'(i) < count_q;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    push_full_no_pop : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_o && !pop_i));
    pop_empty : assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && empty_o));

endmodule

// File: rtl/jedro_1_writeback.sv
// jedro_1_writeback: arbitrates registered ALU results and LSU load returns onto the single
// register-file write port. ALU results that lose arbitration queue in an in-order FIFO;
// stall_o throttles the decoder before the FIFO can overflow.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   alu_res_i/alu_dest_addr_i/alu_reg_wb_i  ALU result, single-cycle valid, no backpressure
//   lsu_rdata_i/lsu_dest_addr_i/lsu_valid_i load return, held until lsu_ready_o
//   lsu_ready_o                          load accepted this cycle (combinational)
//   rf_wdata_o/rf_waddr_o/rf_we_o        registered register-file write
//   stall_o                              registered decoder stall request
// Optional feature, macro JEDRO_1_WB_FWD_EN: adds fwd_raddr_i/fwd_hit_o/fwd_data_o, a
// combinational lookup over queued entries and the registered rf_* write (youngest wins).
module jedro_1_writeback
    import jedro_1_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH     = WB_FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     alu_res_i,
    input  logic [REG_ADDR_WIDTH-1:0] alu_dest_addr_i,
    input  logic                      alu_reg_wb_i,
    input  logic [DATA_WIDTH-1:0]     lsu_rdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_dest_addr_i,
    input  logic                      lsu_valid_i,
    output logic                      lsu_ready_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic                      rf_we_o,
    output logic                      stall_o
`ifdef JEDRO_1_WB_FWD_EN
    ,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_raddr_i,
    output logic                      fwd_hit_o,
    output logic [DATA_WIDTH-1:0]     fwd_data_o
`endif
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + REG_ADDR_WIDTH;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic                             alu_ok;
    logic                             fifo_push, fifo_pop;
    logic                             fifo_full, fifo_empty;
    logic [CNT_W-1:0]                 fifo_count, count_next;
    logic [ENTRY_W-1:0]               fifo_head;
    logic [FIFO_DEPTH-1:0][ENTRY_W-1:0] fifo_entries;
    logic [FIFO_DEPTH-1:0]            fifo_valid;
    wb_sel_e                          sel;

    logic [DATA_WIDTH-1:0]            rf_wdata_q, rf_wdata_d;
    logic [REG_ADDR_WIDTH-1:0]        rf_waddr_q, rf_waddr_d;
    logic                             rf_we_q, rf_we_d;
    logic                             stall_q, stall_d;

    // x0 results are discarded at the door so the FIFO only ever holds real writes.
    assign alu_ok = alu_reg_wb_i && (alu_dest_addr_i != '0);

    always_comb begin
        sel = SelNone;
        if (fifo_full) begin
            sel = SelFifo;
        end else if (lsu_valid_i) begin
            sel = SelLsu;
        end else if (!fifo_empty) begin
            sel = SelFifo;
        end else if (alu_ok) begin
            sel = SelAlu;
        end
    end

    assign lsu_ready_o = !rst_i && (sel == SelLsu);
    assign fifo_pop    = !rst_i && (sel == SelFifo);
    assign fifo_push   = !rst_i && alu_ok && (sel != SelAlu);

    always_comb begin
        rf_wdata_d = rf_wdata_q;
        rf_waddr_d = rf_waddr_q;
        rf_we_d    = 1'b0;
        unique case (sel)
            SelFifo: begin
                rf_we_d    = 1'b1;
                rf_wdata_d = fifo_head[ENTRY_W-1:REG_ADDR_WIDTH];
                rf_waddr_d = fifo_head[REG_ADDR_WIDTH-1:0];
            end
            SelLsu: begin
                // An x0 load still handshakes but never writes.
                rf_we_d    = (lsu_dest_addr_i != '0);
                rf_wdata_d = lsu_rdata_i;
                rf_waddr_d = lsu_dest_addr_i;
            end
            SelAlu: begin
                rf_we_d    = 1'b1;
                rf_wdata_d = alu_res_i;
                rf_waddr_d = alu_dest_addr_i;
            end
            SelNone: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    // Stall one entry early: the ALU may already have a result in flight.
    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign stall_d    = (count_next >= CNT_W'(FIFO_DEPTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_wdata_q <= '0;
            rf_waddr_q <= '0;
            rf_we_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            rf_wdata_q <= rf_wdata_d;
            rf_waddr_q <= rf_waddr_d;
            rf_we_q    <= rf_we_d;
            stall_q    <= stall_d;
        end
    end

    assign rf_wdata_o = rf_wdata_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_we_o    = rf_we_q;
    assign stall_o    = stall_q;

    jedro_1_writeback_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i ({alu_res_i, alu_dest_addr_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
    );

`ifdef JEDRO_1_WB_FWD_EN
    // Later matches override earlier ones: rf stage is oldest, FIFO tail is youngest.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        if (rf_we_q && (rf_waddr_q == fwd_raddr_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = rf_wdata_q;
        end
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (fifo_valid[i] && (fifo_entries[i][REG_ADDR_WIDTH-1:0] == fwd_raddr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = fifo_entries[i][ENTRY_W-1:REG_ADDR_WIDTH];
            end
        end
        if (fwd_raddr_i == '0) begin
            fwd_hit_o  = 1'b0;
            fwd_data_o = '0;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fifo_entries, fifo_valid};
`endif

endmodule

// File: tb/tb_jedro_1_writeback.sv
module tb_jedro_1_writeback;
    import jedro_1_writeback_pkg::*;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res;
    logic [4:0]  alu_addr;
    logic        alu_wb;
    logic [31:0] lsu_rdata;
    logic [4:0]  lsu_addr;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic        stall;
`ifdef JEDRO_1_WB_FWD_EN
    logic [4:0]  fwd_raddr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    jedro_1_writeback dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .alu_res_i       (alu_res),
        .alu_dest_addr_i (alu_addr),
        .alu_reg_wb_i    (alu_wb),
        .lsu_rdata_i     (lsu_rdata),
        .lsu_dest_addr_i (lsu_addr),
        .lsu_valid_i     (lsu_valid),
        .lsu_ready_o     (lsu_ready),
        .rf_wdata_o      (rf_wdata),
        .rf_waddr_o      (rf_waddr),
        .rf_we_o         (rf_we),
        .stall_o         (stall)
`ifdef JEDRO_1_WB_FWD_EN
        ,
        .fwd_raddr_i     (fwd_raddr),
        .fwd_hit_o       (fwd_hit),
        .fwd_data_o      (fwd_data)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the ALU queue as a plain list of pending writes.
    wb_entry_t   q[$];
    wb_entry_t   e;
    logic        exp_we = 1'b0;
    logic [31:0] exp_wdata = '0;
    logic [4:0]  exp_waddr = '0;
    logic        exp_stall = 1'b0;
    bit          model_ok = 1'b0;
    bit          alu_taken;
    logic        exp_hit;
    logic [31:0] exp_fdata;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_we = 1'b0; exp_wdata = '0; exp_waddr = '0; exp_stall = 1'b0;
            model_ok = 1'b1;
        end else begin
            alu_taken = 1'b0;
            exp_we = 1'b0;
            if (q.size() == D || (!lsu_valid && q.size() != 0)) begin
                e = q.pop_front();
                exp_we = 1'b1; exp_wdata = e.data; exp_waddr = e.addr;
            end else if (lsu_valid) begin
                if (lsu_addr != 0) begin
                    exp_we = 1'b1; exp_wdata = lsu_rdata; exp_waddr = lsu_addr;
                end
            end else if (alu_wb && alu_addr != 0) begin
                exp_we = 1'b1; exp_wdata = alu_res; exp_waddr = alu_addr;
                alu_taken = 1'b1;
            end
            if (alu_wb && alu_addr != 0 && !alu_taken) begin
                e.data = alu_res; e.addr = alu_addr;
                q.push_back(e);
            end
            exp_stall = (q.size() >= D - 1);
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("rf_we", rf_we, exp_we);
            check("stall", stall, exp_stall);
            if (exp_we) begin
                check("rf_wdata", rf_wdata, exp_wdata);
                check("rf_waddr", rf_waddr, exp_waddr);
            end
            check("lsu_ready", lsu_ready, !rst && lsu_valid && (q.size() != D));
`ifdef JEDRO_1_WB_FWD_EN
            exp_hit = 1'b0; exp_fdata = '0;
            if (exp_we && exp_waddr == fwd_raddr) begin exp_hit = 1'b1; exp_fdata = exp_wdata; end
            foreach (q[i]) if (q[i].addr == fwd_raddr) begin exp_hit = 1'b1; exp_fdata = q[i].data; end
            if (fwd_raddr == 0) exp_hit = 1'b0;
            check("fwd_hit", fwd_hit, exp_hit);
            if (exp_hit) check("fwd_data", fwd_data, exp_fdata);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_wb = 1'b0; alu_addr = '0; alu_res = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_rdata = '0;
    endtask

    logic lsu_hs;

    initial begin
        rst = 1'b1;
        idle();
`ifdef JEDRO_1_WB_FWD_EN
        fwd_raddr = '0;
`endif
        repeat (2) cyc();
        check("reset_we", rf_we, 1'b0);
        check("reset_wdata", rf_wdata, 32'h0);
        check("reset_waddr", rf_waddr, 5'd0);
        check("reset_stall", stall, 1'b0);
        lsu_valid = 1'b1; lsu_addr = 5'd1;
        #1 check("reset_lsu_ready", lsu_ready, 1'b0);
        idle();
        cyc();
        rst = 1'b0;

        // Idle ALU bypass
        alu_wb = 1'b1; alu_addr = 5'd5; alu_res = 32'hDEADBEEF;
        cyc(); idle();
        check("t1_we", rf_we, 1'b1);
        check("t1_waddr", rf_waddr, 5'd5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
        cyc();
        check("t1_idle_we", rf_we, 1'b0);

        // ALU/LSU conflict
        alu_wb = 1'b1; alu_addr = 5'd3; alu_res = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_rdata = 32'h22;
        #1 check("t2_ready", lsu_ready, 1'b1);
        cyc(); idle();
        check("t2_first_waddr", rf_waddr, 5'd4);
        check("t2_first_wdata", rf_wdata, 32'h22);
        cyc();
        check("t2_second_waddr", rf_waddr, 5'd3);
        check("t2_second_wdata", rf_wdata, 32'h11);
        cyc();
        check("t2_done_we", rf_we, 1'b0);

        // LSU held while ALU fills the FIFO
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_rdata = 32'h99;
        for (int i = 0; i < 4; i++) begin
            alu_wb = 1'b1; alu_addr = 5'(10 + i); alu_res = 32'h100 + 32'(i);
            cyc();
            if (i == 1) check("t3_stall_at2", stall, 1'b0);
            if (i == 2) check("t3_stall_at3", stall, 1'b1);
        end
        alu_wb = 1'b0;
        #1 check("t3_full_ready", lsu_ready, 1'b0);
        cyc();
        check("t3_drain0", rf_waddr, 5'd10);
        check("t3_drain0_d", rf_wdata, 32'h100);
        cyc();
        check("t3_lsu_waddr", rf_waddr, 5'd9);
        lsu_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            cyc();
            check("t3_drain_waddr", rf_waddr, 5'(10 + i));
            check("t3_drain_wdata", rf_wdata, 32'h100 + 32'(i));
        end
        cyc();
        check("t3_end_we", rf_we, 1'b0);
        check("t3_end_stall", stall, 1'b0);

        // x0 filter
        alu_wb = 1'b1; alu_addr = 5'd0; alu_res = 32'h5;
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_rdata = 32'h6;
        #1 check("t4_ready", lsu_ready, 1'b1);
        cyc(); idle();
        check("t4_we0", rf_we, 1'b0);
        cyc();
        check("t4_we1", rf_we, 1'b0);

        // Reset drops queued entries
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_rdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            alu_wb = 1'b1; alu_addr = 5'(20 + i); alu_res = 32'h200 + 32'(i);
            cyc();
        end
        idle(); rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t5_we", rf_we, 1'b0);
        check("t5_stall", stall, 1'b0);
        repeat (4) begin
            cyc();
            check("t5_no_write", rf_we, 1'b0);
        end

`ifdef JEDRO_1_WB_FWD_EN
        // Forwarding: youngest queued x7 wins, x0 never hits
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_rdata = 32'h99;
        alu_wb = 1'b1; alu_addr = 5'd7; alu_res = 32'hA;
        cyc();
        alu_res = 32'hB;
        cyc();
        alu_wb = 1'b0; fwd_raddr = 5'd7;
        #1 check("t6_hit", fwd_hit, 1'b1);
        check("t6_data", fwd_data, 32'hB);
        fwd_raddr = 5'd0;
        #1 check("t6_x0_hit", fwd_hit, 1'b0);
        fwd_raddr = 5'd9;
        #1 check("t6_rf_hit", fwd_hit, 1'b1);
        check("t6_rf_data", fwd_data, 32'h99);
        idle();
        repeat (3) cyc();
`endif

        // Randomized traffic
        lsu_hs = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (!lsu_valid || lsu_hs) begin
                lsu_valid = ($urandom_range(2) == 0);
                lsu_addr  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                lsu_rdata = $urandom;
            end
            alu_wb   = ($urandom_range(1) == 1);
            alu_addr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            alu_res  = $urandom;
            rst      = ($urandom_range(99) == 0);
`ifdef JEDRO_1_WB_FWD_EN
            fwd_raddr = 5'($urandom_range(31));
`endif
            #1 lsu_hs = lsu_valid && lsu_ready;
            cyc();
        end
        rst = 1'b0;
        idle();
        repeat (8) cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
